// File: rtl/alu_src_arbiter_if.sv
// Bundle of request/grant/data signals between the requesters and the
// round-robin ALU source arbiter. The arbiter sits on the slave modport.
// The requester side (or a testbench) uses the master modport.
interface alu_src_arbiter_if #(
    parameter int W = 16
);
    logic [15:0]     req;           // per-requester request, held for the transaction
    logic            ready;         // downstream ALU consumer takes a beat
    logic [16*W-1:0] mux_d;         // flattened requester data, slice i = mux_d[i*W +: W]
    logic [15:0]     grant;         // registered one-hot grant
    logic [3:0]      sel;           // operand mux select = owner index
    logic            valid;         // owner's request present this cycle
    logic            beat;          // beat accepted
    logic [W-1:0]    owner_data_o;  // owner's data slice

    modport master (
        output req, ready, mux_d,
        input  grant, sel, valid, beat, owner_data_o
    );

    modport slave (
        input  req, ready, mux_d,
        output grant, sel, valid, beat, owner_data_o
    );
endinterface

// File: rtl/alu_src_arbiter.sv
// Round-robin arbiter for the shared 16-input ALU operand/result mux.
// It issues a registered one-hot grant and holds it for a multi-cycle
// transaction. On release it hands over to the next pending requester
// with no idle cycle in between.
// Optional feature macro: ALU_ARB_BURST_LIMIT_EN. When it is defined, an
// owner is forced out after MAX_BURST accepted beats if anyone else waits.
module alu_src_arbiter #(
    parameter int W         = 16,
    parameter int MAX_BURST = 4
) (
    input logic             clk,
    input logic             rst_b,
    alu_src_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         owner_q, owner_d;
    logic [3:0]         ptr_q,   ptr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [15:0]        grant_q, grant_d;

    logic               owner_req;
    logic               valid;
    logic               beat;
    logic               do_release;
    logic [4:0]         idle_pick;   // {found, index}
    logic [4:0]         rel_pick;    // {found, index}

    // First asserted bit scanning start, start+1, ... modulo 16.
    // The scan runs from the far end so the closest hit is written last.
    function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] start);
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int i = 15; i >= 0; i--) begin
            idx = start + 4'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Owner status and the two arbitration candidates: fresh grant from IDLE,
    // and hand-over with the current owner's bit masked out.
    assign owner_req = bus.req[owner_q];
    assign valid     = (state_q == GRANT) && owner_req;
    assign beat      = valid && bus.ready;
    assign idle_pick = rr_pick(bus.req, ptr_q);
    assign rel_pick  = rr_pick(bus.req & ~grant_q, owner_q + 4'd1);

`ifdef ALU_ARB_BURST_LIMIT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    logic burst_done;
    logic others_pending;

    // Forced rotation only when the last beat of a burst lands and someone waits.
    assign others_pending = |(bus.req & ~grant_q);
    assign burst_done     = beat && (cnt_q == CNT_LAST);
    assign do_release     = !owner_req || (burst_done && others_pending);
`else
    assign do_release = !owner_req;
`endif

    // Next-state logic: arbitration, hand-over and beat counting.
    always_comb begin
        // NOTE: every value assigned below gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;

        case (state_q)
            IDLE: begin
                if (idle_pick[4]) begin
                    state_d = GRANT;
                    owner_d = idle_pick[3:0];
                    grant_d = 16'd1 << idle_pick[3:0];
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (do_release) begin
                    ptr_d = owner_q + 4'd1;
                    cnt_d = '0;
                    if (rel_pick[4]) begin
                        owner_d = rel_pick[3:0];
                        grant_d = 16'd1 << rel_pick[3:0];
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                        grant_d = '0;
                    end
                end else if (beat) begin
`ifdef ALU_ARB_BURST_LIMIT_EN
                    // Burst complete with nobody waiting: start a new burst.
                    cnt_d = burst_done ? '0 : cnt_q + 1'b1;
`else
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_b) begin
        // NOTE: sequential state uses non-blocking assignments only. The
        // asynchronous reset clears the grant without waiting for a clock.
        if (!rst_b) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    // Outputs: select follows the owner register (zero while idle) and only
    // the selected slice reaches the shared path.
    assign bus.grant        = grant_q;
    assign bus.sel          = owner_q;
    assign bus.valid        = valid;
    assign bus.beat         = beat;
    assign bus.owner_data_o = bus.mux_d[owner_q*W +: W];

endmodule

// File: tb/tb_alu_src_arbiter.sv
// Scoreboard testbench for alu_src_arbiter. The stimulus drives each cycle's
// inputs and queues the expected outputs for that cycle. A monitor pops one
// entry and compares it on every falling edge.
// Mux data slice i carries 0xA000+i, so the forwarded data identifies the owner.
module tb_alu_src_arbiter;

    localparam int W = 16;

    logic clk;
    logic rst_b;

    alu_src_arbiter_if #(.W(W)) bus ();

    alu_src_arbiter #(.W(W), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    typedef struct {
        int   own;   // expected owner index, -1 when idle
        logic v;     // expected valid
        logic b;     // expected beat
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: new inputs just after the rising edge, plus the expected
    // response for this cycle (grant reflects the previous edge).
    task automatic step(input logic [15:0] r, input logic rdy, input int own,
                        input logic v, input logic b);
        exp_t e;
        @(posedge clk);
        #1;
        bus.req   = r;
        bus.ready = rdy;
        e.own = own;
        e.v   = v;
        e.b   = b;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_b   = 1'b0;
        bus.req = '0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    // Monitor: compares all outputs against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [15:0] eg;
            logic [3:0]  es;
            e  = exp_q.pop_front();
            eg = (e.own < 0) ? 16'h0000 : (16'd1 << e.own);
            es = (e.own < 0) ? 4'd0 : 4'(e.own);
            check("grant", 32'(bus.grant), 32'(eg));
            check("sel",   32'(bus.sel),   32'(es));
            check("valid", 32'(bus.valid), 32'(e.v));
            check("beat",  32'(bus.beat),  32'(e.b));
            check("data",  32'(bus.owner_data_o), 32'(16'hA000 + 16'(es)));
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_b     = 1'b0;
        bus.req   = '0;
        bus.ready = 1'b0;
        for (int i = 0; i < 16; i++) bus.mux_d[i*W +: W] = 16'hA000 + 16'(i);
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_sel",   32'(bus.sel),   32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        rst_b = 1'b1;

        // Single request 4, drop to IDLE, ptr becomes 5.
        step(16'h0010, 1'b1, -1, 1'b0, 1'b0);
        step(16'h0010, 1'b1,  4, 1'b1, 1'b1);
        step(16'h0000, 1'b1,  4, 1'b0, 1'b0);
        step(16'h0000, 1'b1, -1, 1'b0, 1'b0);
        // ptr=5: requests 0 and 4 -> 0 wins, then 4 without a bubble.
        step(16'h0011, 1'b1, -1, 1'b0, 1'b0);
        step(16'h0011, 1'b1,  0, 1'b1, 1'b1);
        step(16'h0010, 1'b1,  0, 1'b0, 1'b0);
        step(16'h0010, 1'b1,  4, 1'b1, 1'b1);
        step(16'h0000, 1'b1,  4, 1'b0, 1'b0);
        step(16'h0000, 1'b1, -1, 1'b0, 1'b0);

        // Data routing with owner 9 and ready toggling 1,0,1 (ptr 5 -> 10).
        step(16'h0200, 1'b1, -1, 1'b0, 1'b0);
        step(16'h0200, 1'b1,  9, 1'b1, 1'b1);
        step(16'h0200, 1'b0,  9, 1'b1, 1'b0);
        step(16'h0200, 1'b1,  9, 1'b1, 1'b1);
        step(16'h0000, 1'b1,  9, 1'b0, 1'b0);
        step(16'h0000, 1'b1, -1, 1'b0, 1'b0);

        // Async reset mid-grant with owner 7.
        step(16'h0080, 1'b1, -1, 1'b0, 1'b0);
        step(16'h0080, 1'b1,  7, 1'b1, 1'b1);
        @(negedge clk);
        #2;
        rst_b   = 1'b0;
        bus.req = '0;
        #1;
        check("async_grant", 32'(bus.grant), 32'h0);
        check("async_sel",   32'(bus.sel),   32'h0);
        check("async_valid", 32'(bus.valid), 32'h0);
        check("async_beat",  32'(bus.beat),  32'h0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        // ptr back to 0: 0x0081 -> owner 0, then 7.
        step(16'h0081, 1'b1, -1, 1'b0, 1'b0);
        step(16'h0081, 1'b1,  0, 1'b1, 1'b1);
        step(16'h0080, 1'b1,  0, 1'b0, 1'b0);
        step(16'h0080, 1'b1,  7, 1'b1, 1'b1);
        step(16'h0000, 1'b1,  7, 1'b0, 1'b0);
        step(16'h0000, 1'b1, -1, 1'b0, 1'b0);

        // Fairness: everyone requests; each owner takes one beat, then drops.
        do_reset();
        step(16'hFFFF, 1'b1, -1, 1'b0, 1'b0);
        for (int o = 0; o < 16; o++) begin
            step(16'hFFFF, 1'b1, o, 1'b1, 1'b1);
            step(16'hFFFF & ~(16'd1 << o), 1'b1, o, 1'b0, 1'b0);
        end
        step(16'hFFFF, 1'b1,  0, 1'b1, 1'b1);
        step(16'h0000, 1'b1,  0, 1'b0, 1'b0);
        step(16'h0000, 1'b1, -1, 1'b0, 1'b0);

        // Move ptr to 14 via owner 13, then wrap: order 15, 0, 1.
        step(16'h2000, 1'b1, -1, 1'b0, 1'b0);
        step(16'h2000, 1'b1, 13, 1'b1, 1'b1);
        step(16'h0000, 1'b1, 13, 1'b0, 1'b0);
        step(16'h8003, 1'b1, -1, 1'b0, 1'b0);
        step(16'h8003, 1'b1, 15, 1'b1, 1'b1);
        step(16'h0003, 1'b1, 15, 1'b0, 1'b0);
        step(16'h0003, 1'b1,  0, 1'b1, 1'b1);
        step(16'h0002, 1'b1,  0, 1'b0, 1'b0);
        step(16'h0002, 1'b1,  1, 1'b1, 1'b1);
        step(16'h0000, 1'b1,  1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, -1, 1'b0, 1'b0);

        // Requests 1 and 2 both held with ready high.
        do_reset();
        step(16'h0006, 1'b1, -1, 1'b0, 1'b0);
`ifdef ALU_ARB_BURST_LIMIT_EN
        for (int k = 0; k < 4; k++) step(16'h0006, 1'b1, 1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(16'h0006, 1'b1, 2, 1'b1, 1'b1);
        step(16'h0006, 1'b1, 1, 1'b1, 1'b1);
        // Alone: owner 1 keeps the grant beyond 4 beats.
        for (int k = 0; k < 6; k++) step(16'h0002, 1'b1, 1, 1'b1, 1'b1);
        step(16'h0000, 1'b1,  1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, -1, 1'b0, 1'b0);
`else
        // No burst limit: owner 1 keeps the grant until it drops.
        for (int k = 0; k < 6; k++) step(16'h0006, 1'b1, 1, 1'b1, 1'b1);
        step(16'h0004, 1'b1,  1, 1'b0, 1'b0);
        step(16'h0004, 1'b1,  2, 1'b1, 1'b1);
        step(16'h0000, 1'b1,  2, 1'b0, 1'b0);
        step(16'h0000, 1'b1, -1, 1'b0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
